// File: rtl/i2d_core_defines.sv
// Shared definitions for the i2d core: access sizes, MAU states
// and the alignment rule used by the memory access unit.
package i2d_core_defines;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef enum logic {
      IDLE,
      BUSY
   } mau_state_t;

   // Size 3 has no encoding and is reported like a misalignment
   function automatic logic misaligned(
      input logic [1:0] size,
      input logic [1:0] lane
   );
      logic bad;
      bad = 1'b0;
      case (size)
         SIZE_BYTE: bad = 1'b0;
         SIZE_HALF: bad = lane[0];
         SIZE_WORD: bad = |lane;
         default:   bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mau_lane.sv
// Byte-lane steering for the MAU: store enables/replication and
// load lane extraction with zero/sign extension.
module mau_lane
   import i2d_core_defines::*;
(
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_lane,
   input  logic [31:0] st_data,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   input  logic [1:0]  ld_size,
   input  logic [1:0]  ld_lane,
   input  logic        ld_signed,
   input  logic [31:0] rdata,
   output logic [31:0] ldata
);

   logic [7:0]  ld_b;
   logic [15:0] ld_h;

   always_comb begin
      be    = 4'b0000;
      wdata = st_data;
      case (st_size)
         SIZE_BYTE: begin
            be    = 4'b0001 << st_lane;
            wdata = {4{st_data[7:0]}};
         end
         SIZE_HALF: begin
            be    = st_lane[1] ? 4'b1100 : 4'b0011;
            wdata = {2{st_data[15:0]}};
         end
         SIZE_WORD: be = 4'b1111;
         default:   be = 4'b0000;
      endcase
   end

   always_comb begin
      ld_b  = rdata[{ld_lane, 3'b000} +: 8];
      ld_h  = ld_lane[1] ? rdata[31:16] : rdata[15:0];
      ldata = rdata;
      case (ld_size)
         SIZE_BYTE: ldata = {{24{ld_signed & ld_b[7]}}, ld_b};
         SIZE_HALF: ldata = {{16{ld_signed & ld_h[15]}}, ld_h};
         default:   ldata = rdata;
      endcase
   end

endmodule

// File: rtl/core_mau.sv
// i2d memory access unit: single-outstanding req/ack data bus
// transaction with execute-stage halt, timeout and fault report.
module core_mau
   import i2d_core_defines::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_ld,
   input  logic        mem_st,
   input  logic [1:0]  mem_size,
   input  logic        mem_signed,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [31:0] dbus_addr,
   output logic [3:0]  dbus_be,
   output logic [31:0] dbus_wdata,
   input  logic        dbus_ack,
   input  logic [31:0] dbus_rdata,
   output logic [31:0] mau_data,
   output logic        ex_halt,
   output logic        mau_fault
);

   // Last BUSY cycle allowed before the request is abandoned
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   mau_state_t  state, state_nxt;
   logic [7:0]  cnt;
   logic [1:0]  size_q;
   logic [1:0]  lane_q;
   logic        signed_q;
   logic [3:0]  be_nxt;
   logic [31:0] wdata_nxt;
   logic [31:0] ldata;
   logic        req;
   logic        bad;
   logic        go;
   logic        done;
   logic        timeout;

   assign req      = mem_ld | mem_st;
   assign bad      = misaligned(mem_size, mem_addr[1:0]);
   assign dbus_req = (state == BUSY);

   mau_lane u_lane (
      .st_size   (mem_size),
      .st_lane   (mem_addr[1:0]),
      .st_data   (mem_wdata),
      .be        (be_nxt),
      .wdata     (wdata_nxt),
      .ld_size   (size_q),
      .ld_lane   (lane_q),
      .ld_signed (signed_q),
      .rdata     (dbus_rdata),
      .ldata     (ldata)
   );

   always_comb begin
      state_nxt = state;
      go        = 1'b0;
      done      = 1'b0;
      timeout   = 1'b0;
      ex_halt   = 1'b0;
      case (state)
         IDLE: begin
            if (req && !bad) begin
               go        = 1'b1;
               ex_halt   = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (dbus_ack) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end else if (cnt == CNT_LAST) begin
               timeout   = 1'b1;
               state_nxt = IDLE;
            end else begin
               ex_halt   = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 8'd0;
         dbus_we    <= 1'b0;
         dbus_addr  <= 32'd0;
         dbus_be    <= 4'd0;
         dbus_wdata <= 32'd0;
         size_q     <= SIZE_BYTE;
         lane_q     <= 2'd0;
         signed_q   <= 1'b0;
         mau_data   <= 32'd0;
         mau_fault  <= 1'b0;
      end else begin
         state     <= state_nxt;
         mau_fault <= (state == IDLE && req && bad) || timeout;
         if (go) begin
            cnt        <= 8'd0;
            dbus_we    <= mem_st & ~mem_ld;
            dbus_addr  <= {mem_addr[31:2], 2'b00};
            dbus_be    <= be_nxt;
            dbus_wdata <= wdata_nxt;
            size_q     <= mem_size;
            lane_q     <= mem_addr[1:0];
            signed_q   <= mem_signed;
         end else if (state == BUSY && !dbus_ack) begin
            cnt <= cnt + 8'd1;
         end
         if (done && !dbus_we) mau_data <= ldata;
      end
   end

endmodule

// File: tb/tb_core_mau.sv
// Self-checking bench for core_mau: directed scenarios plus random
// accesses against an arithmetic reference model of the MAU.
module tb_core_mau;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_ld, mem_st, mem_signed;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata;
   logic        dbus_req, dbus_we, dbus_ack;
   logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
   logic [3:0]  dbus_be;
   logic [31:0] mau_data;
   logic        ex_halt, mau_fault;

   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_data = 32'd0;

   core_mau #(.TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_ld     (mem_ld),
      .mem_st     (mem_st),
      .mem_size   (mem_size),
      .mem_signed (mem_signed),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .dbus_req   (dbus_req),
      .dbus_we    (dbus_we),
      .dbus_addr  (dbus_addr),
      .dbus_be    (dbus_be),
      .dbus_wdata (dbus_wdata),
      .dbus_ack   (dbus_ack),
      .dbus_rdata (dbus_rdata),
      .mau_data   (mau_data),
      .ex_halt    (ex_halt),
      .mau_fault  (mau_fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit m_bad(input int size, input int addr);
      if (size == 3) return 1;
      if (size == 1) return (addr % 2) != 0;
      if (size == 2) return (addr % 4) != 0;
      return 0;
   endfunction

   function automatic logic [31:0] m_be(input int size, input int addr);
      int lane = addr % 4;
      if (size == 0) return 32'(1 << lane);
      if (size == 1) return 32'(3 << (lane / 2 * 2));
      return 32'd15;
   endfunction

   function automatic logic [31:0] m_wd(input int size, input longint wd);
      if (size == 0) return 32'((wd % 256) * 64'h01010101);
      if (size == 1) return 32'((wd % 65536) * 64'h00010001);
      return 32'(wd);
   endfunction

   function automatic logic [31:0] m_ld(input int size, input bit sgn,
                                        input int addr, input longint rd);
      longint v;
      longint lim;
      if (size == 2) return 32'(rd);
      lim = (size == 0) ? 256 : 65536;
      v = (rd >> (8 * (addr % 4))) % lim;
      if (sgn && v >= lim / 2) v = v - lim;
      return 32'(v);
   endfunction

   // Called just after a falling edge; returns just after the falling
   // edge that follows completion, so a new access may start at once.
   task automatic access(input logic ld, input logic st,
                         input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int ackd);
      bit mis = m_bad(int'(size), int'(addr[1:0]));
      bit is_st = st && !ld;
      bit fin = 0;
      bit ack_now;
      mem_ld = ld; mem_st = st; mem_size = size; mem_signed = sgn;
      mem_addr = addr; mem_wdata = wd; dbus_ack = 1'b0;
      #1 chk("halt_req", 32'(ex_halt), 32'(!mis));
      @(negedge clk);
      mem_ld = 1'b0; mem_st = 1'b0;
      if (mis) begin
         chk("mis_fault", 32'(mau_fault), 32'd1);
         chk("mis_req", 32'(dbus_req), 32'd0);
         #1 chk("mis_halt", 32'(ex_halt), 32'd0);
         return;
      end
      for (int k = 0; k < TO && !fin; k++) begin
         chk("req", 32'(dbus_req), 32'd1);
         chk("fault_busy", 32'(mau_fault), 32'd0);
         chk("we", 32'(dbus_we), 32'(is_st));
         chk("addr", dbus_addr, {addr[31:2], 2'b00});
         chk("be", 32'(dbus_be), m_be(int'(size), int'(addr[1:0])));
         if (is_st) chk("wdata", dbus_wdata, m_wd(int'(size), longint'(wd)));
         ack_now = (k == ackd);
         dbus_ack = ack_now; dbus_rdata = rd;
         fin = ack_now || (k == TO - 1);
         #1 chk("halt_busy", 32'(ex_halt), 32'(!fin));
         @(negedge clk);
         dbus_ack = 1'b0; dbus_rdata = $urandom;
         if (fin) begin
            if (ack_now && !is_st)
               exp_data = m_ld(int'(size), sgn, int'(addr[1:0]),
                               longint'(rd));
            chk("req_end", 32'(dbus_req), 32'd0);
            chk("fault_end", 32'(mau_fault), 32'(!ack_now));
            chk("mau_data", mau_data, exp_data);
         end
      end
   endtask

   task automatic idle();
      @(negedge clk);
      chk("idle_fault", 32'(mau_fault), 32'd0);
      chk("idle_req", 32'(dbus_req), 32'd0);
   endtask

   initial begin
      rst = 1'b1; mem_ld = 1'b0; mem_st = 1'b0; mem_size = 2'd0;
      mem_signed = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0;
      dbus_ack = 1'b0; dbus_rdata = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req", 32'(dbus_req), 32'd0);
      chk("rst_we", 32'(dbus_we), 32'd0);
      chk("rst_addr", dbus_addr, 32'd0);
      chk("rst_be", 32'(dbus_be), 32'd0);
      chk("rst_wdata", dbus_wdata, 32'd0);
      chk("rst_data", mau_data, 32'd0);
      chk("rst_fault", 32'(mau_fault), 32'd0);
      rst = 1'b0;
      idle();

      access(1, 0, 2'd0, 1, 32'h1003, 32'h0, 32'h80AABBCC, 1);
      chk("lb_val", mau_data, 32'hFFFFFF80);
      access(0, 1, 2'd1, 0, 32'h2002, 32'h0000BEEF, 32'h0, 0);
      chk("sh_keep", mau_data, 32'hFFFFFF80);
      access(1, 0, 2'd2, 0, 32'h0001, 32'h0, 32'h0, 0);
      idle();
      access(1, 0, 2'd2, 0, 32'h0020, 32'h0, 32'h5555AAAA, 99);
      idle();
      access(1, 0, 2'd2, 0, 32'h0024, 32'h0, 32'hCAFEF00D, TO - 1);
      access(1, 0, 2'd2, 0, 32'h0010, 32'h0, 32'h0BADBEEF, 0);
      access(1, 0, 2'd1, 0, 32'h0016, 32'h0, 32'h12345678, 0);
      chk("lhu_val", mau_data, 32'h00001234);
      access(1, 1, 2'd0, 0, 32'h0031, 32'h0, 32'h00009900, 2);

      mem_ld = 1'b1; mem_size = 2'd2; mem_addr = 32'h40;
      @(negedge clk);
      mem_ld = 1'b0;
      chk("pre_rst_req", 32'(dbus_req), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_data = 32'd0;
      chk("mid_rst_req", 32'(dbus_req), 32'd0);
      chk("mid_rst_addr", dbus_addr, 32'd0);
      chk("mid_rst_be", 32'(dbus_be), 32'd0);
      chk("mid_rst_data", mau_data, 32'd0);
      chk("mid_rst_fault", 32'(mau_fault), 32'd0);
      #1 chk("mid_rst_halt", 32'(ex_halt), 32'd0);
      access(1, 0, 2'd2, 0, 32'h0044, 32'h0, 32'h76543210, 1);

      for (int i = 0; i < 60; i++) begin
         logic [31:0] a;
         logic [1:0]  sz;
         logic        l, s;
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'($urandom_range(0, 3)) & 2'b10;
         sz = 2'($urandom_range(0, 3));
         l = 1'($urandom_range(0, 1));
         s = !l || ($urandom_range(0, 7) == 0);
         access(l, s, sz, 1'($urandom), a, $urandom, $urandom,
                $urandom_range(0, TO + 1));
         if ($urandom_range(0, 2) == 0) idle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/core_mau.md
# core_mau

Memory access unit for the i2d core. Accepts load/store requests from the decode side, runs a single-outstanding request/acknowledge transaction on the data bus, and drives `ex_halt` to freeze the execute stage while the access is in flight. On completion it presents the aligned, size-adjusted load value on `mau_data`, which the execute stage selects for `OPCODE_LD` writeback. Misaligned accesses and bus timeouts are reported on `mau_fault` instead of touching the bus.

## Interface
Parameters:
- `TIMEOUT`, 255: cycles a bus request is held without `dbus_ack` before abort; must be 1..255 (8-bit counter).

Ports:
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `mem_ld` in 1: load request this cycle.
- `mem_st` in 1: store request this cycle; `mem_ld && mem_st` is illegal; treat as load.
- `mem_size` in 2: `SIZE_BYTE`=0, `SIZE_HALF`=1, `SIZE_WORD`=2; 3 is illegal and faults.
- `mem_signed` in 1: sign-extend byte/half loads.
- `mem_addr` in 32: byte address (from ALU result).
- `mem_wdata` in 32: store data, right-justified.
- `dbus_req` out 1: bus request, held until ack.
- `dbus_we` out 1: 1 = write.
- `dbus_addr` out 32: word-aligned address (`{addr[31:2],2'b00}`).
- `dbus_be` out 4: byte enables.
- `dbus_wdata` out 32: lane-replicated store data.
- `dbus_ack` in 1: transfer complete this cycle.
- `dbus_rdata` in 32: read word, valid with `dbus_ack`.
- `mau_data` out 32: last completed load value.
- `ex_halt` out 1: stall execute and upstream.
- `mau_fault` out 1: one-cycle pulse on misalignment/timeout.

## Operation
- States: `IDLE`, `BUSY`.
- IDLE, request (`mem_ld|mem_st`) present:
  - Misaligned (half with `addr[0]`, word with `addr[1:0]!=0`, or size 3): no bus access, `mau_fault`=1 next cycle, stay IDLE, no halt.
  - Otherwise: register addr/we/be/wdata/size/signed/lane, go BUSY; `ex_halt`=1 combinationally in this cycle.
- BUSY: `dbus_req`=1 with stable outputs. On `dbus_ack`: if load, update `mau_data`; go IDLE; `ex_halt`=0 in the ack cycle. Request inputs are ignored while BUSY.
- Timeout: counter cleared on entry to BUSY, increments each BUSY cycle without ack; when it reaches `TIMEOUT`, drop request, `mau_fault` pulse, go IDLE, `mau_data` unchanged. Ack in the same cycle as reaching `TIMEOUT` wins (normal completion).
- `ex_halt` = (IDLE && valid aligned request) || (BUSY && !dbus_ack && !timeout).
- Byte enables: byte `4'b0001<<addr[1:0]`; half `addr[1]?4'b1100:4'b0011`; word `4'b1111`.
- Store data: byte replicated ×4, half ×2, word as-is.
- Load extraction: select lane by registered `addr[1:0]`; zero- or sign-extend per `mem_signed`; word ignores `mem_signed`.

## Timing
- Reset: state IDLE, `dbus_req`=0, `dbus_we`=0, `dbus_addr`=0, `dbus_be`=0, `dbus_wdata`=0, `mau_data`=0, `mau_fault`=0, counter 0. Reset mid-transaction abandons it with no fault; the bus must tolerate a dropped request.
- Minimum access: request cycle N, `dbus_req` high N+1, ack at N+1 → `mau_data` valid N+2, `ex_halt` high only in N.
- Ack at cycle N+k: `ex_halt` high cycles N..N+k-1.
- New request is accepted in the IDLE cycle immediately after ack; back-to-back accesses have no bubble beyond the halt.
- `mau_fault` is registered; never coincides with `dbus_req` for the same access.

## Structure
- Shared package `i2d_core_defines.sv` holds the `SIZE_*` constants and `mau_state_t` enum.
- Sub-module `mau_lane`: pure combinational be/wdata generation and load extraction/extension, unit-testable alone.

## Test plan
- LB signed, addr 0x1003, rdata 0x80AABBCC, ack after 2 cycles → be 4'b1000, `mau_data`=0xFFFFFF80, halt 2 cycles.
- SH addr 0x2002, wdata 0x0000BEEF, immediate ack → `dbus_wdata`=0xBEEFBEEF, be 4'b1100, `dbus_we`=1, `mau_data` unchanged.
- LW addr 0x0001 → no `dbus_req`, `mau_fault` one cycle, `ex_halt` never high.
- `TIMEOUT`=4, LW with no ack → `dbus_req` for 4 cycles then low, `mau_fault` pulse, IDLE; ack on 4th cycle instead → normal completion, no fault.
- Back-to-back LW 0x10 then LHU 0x16 (rdata 0x12345678) → second request accepted cycle after first ack; `mau_data`=0x00001234.
- `rst` asserted while BUSY → next cycle all outputs at reset values, subsequent load completes normally.
